// File: rtl/io_input_reader_pkg.sv
// Shared constants for the switch-input read peripheral: register map and bus width.
package io_input_reader_pkg;

    localparam int          DATA_W       = 32;
    localparam logic [5:0]  DEFAULT_BASE = 6'b000100;

    localparam logic [5:0]  REG_STATE    = 6'd0;
    localparam logic [5:0]  REG_EDGE     = 6'd1;
    localparam logic [5:0]  REG_CNT      = 6'd2;

    // Word offset of a bus address relative to the peripheral base; wraps like the bus adder.
    function automatic logic [5:0] reg_offset(input logic [5:0] addr, input logic [5:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/io_input_reader_if.sv
// Word-addressed peripheral read bus plus the edge interrupt line.
interface io_input_reader_if;
    import io_input_reader_pkg::*;

    logic [5:0]        Add;
    logic              Read;
    logic [DATA_W-1:0] RData;
    logic              RValid;
    logic              IrqEdge;

    modport master (output Add, output Read, input RData, input RValid, input IrqEdge);
    modport slave  (input Add, input Read, output RData, output RValid, output IrqEdge);

endinterface

// File: rtl/io_input_reader_input_debounce.sv
// Two-flop synchroniser followed by a whole-vector debouncer that commits a new
// switch value only after it has stayed stable for DB_CYCLES synced cycles.
module input_debounce #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] state,
    output logic             update,
    output logic [WIDTH-1:0] rise
);

    localparam int            CW     = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] cand_q,  cand_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CW-1:0]    dbcnt_q, dbcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            state_q <= '0;
            dbcnt_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            state_q <= state_d;
            dbcnt_q <= dbcnt_d;
        end
    end

    // Any difference from the candidate restarts the stability window; the
    // counter parks at its maximum once the candidate has been committed.
    always_comb begin
        sync1_d = sw;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        state_d = state_q;
        dbcnt_d = dbcnt_q;
        update  = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d  = sync2_q;
            dbcnt_d = '0;
        end else if (dbcnt_q == DB_MAX && cand_q != state_q) begin
            state_d = cand_q;
            update  = 1'b1;
        end else if (dbcnt_q != DB_MAX) begin
            dbcnt_d = dbcnt_q + 1'b1;
        end
    end

    assign state = state_q;
    assign rise  = cand_q & ~state_q;

endmodule

// File: rtl/io_input_reader.sv
// Memory-mapped switch reader: debounced state, sticky rising-edge flags and a
// saturating change counter, read back one cycle after each Read strobe.
module io_input_reader
    import io_input_reader_pkg::*;
#(
    parameter int         WIDTH     = 8,
    parameter int         DB_CYCLES = 16,
    parameter logic [5:0] BASE      = DEFAULT_BASE
) (
    input  logic             Clk,
    input  logic             Rst_n,
    io_input_reader_if.slave bus,
    input  logic [WIDTH-1:0] SW
);

    logic [WIDTH-1:0]  db_state;
    logic              db_update;
    logic [WIDTH-1:0]  db_rise;

    logic [WIDTH-1:0]  edge_q,   edge_d;
    logic [7:0]        cnt_q,    cnt_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              irq_q,    irq_d;

    logic [5:0]        offset;
    logic              rd_edge;
    logic              rd_cnt;
    logic [WIDTH-1:0]  set_bits;
    logic [DATA_W-1:0] state_ext;
    logic [DATA_W-1:0] edge_ext;

    input_debounce #(
        .WIDTH     (WIDTH),
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .sw     (SW),
        .state  (db_state),
        .update (db_update),
        .rise   (db_rise)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            edge_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            edge_q   <= edge_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

    // Clear-on-read loses to a same-cycle update: the read returns the old
    // snapshot while the registers restart from whatever the update just set.
    always_comb begin
        offset    = reg_offset(bus.Add, BASE);
        rd_edge   = bus.Read && (offset == REG_EDGE);
        rd_cnt    = bus.Read && (offset == REG_CNT);
        set_bits  = db_update ? db_rise : '0;

        state_ext = '0;
        state_ext[WIDTH-1:0] = db_state;
        edge_ext  = '0;
        edge_ext[WIDTH-1:0]  = edge_q;

        edge_d = rd_edge ? set_bits : (edge_q | set_bits);

        cnt_d = cnt_q;
        if (rd_cnt) begin
            cnt_d = db_update ? 8'd1 : 8'd0;
        end else if (db_update && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end

        irq_d    = |edge_d;
        rvalid_d = bus.Read;
        rdata_d  = rdata_q;
        if (bus.Read) begin
            if (offset == REG_STATE) begin
                rdata_d = state_ext;
            end else if (offset == REG_EDGE) begin
                rdata_d = edge_ext;
            end else if (offset == REG_CNT) begin
                rdata_d = {24'b0, cnt_q};
            end else begin
                rdata_d = '0;
            end
        end
    end

    assign bus.RData   = rdata_q;
    assign bus.RValid  = rvalid_q;
    assign bus.IrqEdge = irq_q;

endmodule
